// File: rtl/lynx_pkt_pkg.sv
// Shared NoC packet definitions for the traffic generator and the network-side sink.
// Field positions, data-counter sizing, word packing and the generator FSM state type.
package lynx_pkt_pkg;

    localparam int MAX_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } tpg_state_e;

    typedef struct packed {
        int data_pos;
        int id_pos;
        int vc_pos;
        int dst_pos;
        int src_pos;
        int returnvc_pos;
        int return_pos;
    } field_pos_t;

    function automatic int data_counter_width(int width, int n, int num_vc);
        return width - 3 * $clog2(n) - 2 * $clog2(num_vc) - 8;
    endfunction

    // Fields are laid out LSB-first: DATA, ID, VC, DST, SRC, RETURNVC, RETURN.
    function automatic field_pos_t field_positions(int dcw, int n_aw, int vc_aw);
        field_pos_t p;
        p.data_pos     = 0;
        p.id_pos       = dcw;
        p.vc_pos       = dcw + 8;
        p.dst_pos      = p.vc_pos + vc_aw;
        p.src_pos      = p.dst_pos + n_aw;
        p.returnvc_pos = p.src_pos + n_aw;
        p.return_pos   = p.returnvc_pos + vc_aw;
        return p;
    endfunction

    localparam field_pos_t DEFAULT_POS = field_positions(data_counter_width(32, 16, 2), 4, 1);
    localparam int DATA_POS     = DEFAULT_POS.data_pos;
    localparam int ID_POS       = DEFAULT_POS.id_pos;
    localparam int VC_POS       = DEFAULT_POS.vc_pos;
    localparam int DST_POS      = DEFAULT_POS.dst_pos;
    localparam int SRC_POS      = DEFAULT_POS.src_pos;
    localparam int RETURNVC_POS = DEFAULT_POS.returnvc_pos;
    localparam int RETURN_POS   = DEFAULT_POS.return_pos;

    function automatic logic [MAX_WIDTH-1:0] field_mask(int w);
        logic [MAX_WIDTH-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        if (w <= 0)
            return '0;
        return (one << w) - one;
    endfunction

    // A zero-width field (e.g. VC with a single channel) masks to nothing.
    function automatic logic [MAX_WIDTH-1:0] pack(
        input field_pos_t           pos,
        input int                   n_aw,
        input int                   vc_aw,
        input int                   dcw,
        input logic [MAX_WIDTH-1:0] ret,
        input logic [MAX_WIDTH-1:0] retvc,
        input logic [MAX_WIDTH-1:0] src,
        input logic [MAX_WIDTH-1:0] dst,
        input logic [MAX_WIDTH-1:0] vc,
        input logic [MAX_WIDTH-1:0] id,
        input logic [MAX_WIDTH-1:0] data
    );
        logic [MAX_WIDTH-1:0] word;
        word = '0;
        word = word | ((ret   & field_mask(n_aw))  << pos.return_pos);
        word = word | ((retvc & field_mask(vc_aw)) << pos.returnvc_pos);
        word = word | ((src   & field_mask(n_aw))  << pos.src_pos);
        word = word | ((dst   & field_mask(n_aw))  << pos.dst_pos);
        word = word | ((vc    & field_mask(vc_aw)) << pos.vc_pos);
        word = word | ((id    & field_mask(8))     << pos.id_pos);
        word = word | ((data  & field_mask(dcw))   << pos.data_pos);
        return word;
    endfunction

endpackage

// File: rtl/tpg_source.sv
// Traffic pattern generator: injects NUM_TESTS+1 numbered packets into a NoC input port,
// round-robin over a destination range, with an optional idle gap between packets.
module tpg_source
    import lynx_pkt_pkg::*;
#(
    parameter int         WIDTH         = 32,
    parameter int         N             = 16,
    parameter int         NUM_VC        = 2,
    parameter int         N_ADDR_WIDTH  = $clog2(N),
    parameter int         VC_ADDR_WIDTH = $clog2(NUM_VC),
    parameter logic [7:0] ID            = 8'd0,
    parameter int         NODE          = 0,
    parameter int         DEST_BASE     = 0,
    parameter int         NUM_DESTS     = N,
    parameter int         GAP_CYCLES    = 0,
    parameter int         NUM_TESTS     = 1000,
    localparam int        DATA_COUNTER_WIDTH = data_counter_width(WIDTH, N, NUM_VC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic [WIDTH-1:0]              data_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          done,
    output logic [DATA_COUNTER_WIDTH-1:0] sent_count
);

    localparam int         DCW       = DATA_COUNTER_WIDTH;
    localparam int         IDX_W     = (NUM_DESTS > 1) ? $clog2(NUM_DESTS) : 1;
    localparam int         GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam field_pos_t POS       = field_positions(DCW, N_ADDR_WIDTH, VC_ADDR_WIDTH);
    localparam logic [DCW-1:0] LAST_DATA = DCW'(NUM_TESTS + 1);

    if (DATA_COUNTER_WIDTH < 1) begin : g_err_dcw
        $error("tpg_source: DATA_COUNTER_WIDTH must be at least 1");
    end
    if (DATA_COUNTER_WIDTH >= 1 && DATA_COUNTER_WIDTH < 32 &&
        (NUM_TESTS + 1) >= (1 << DATA_COUNTER_WIDTH)) begin : g_err_tests
        $error("tpg_source: NUM_TESTS+1 does not fit in the DATA field");
    end
    if (NUM_DESTS == 0) begin : g_err_dests_zero
        $error("tpg_source: NUM_DESTS must be non-zero");
    end
    if (NUM_DESTS > N) begin : g_err_dests_big
        $error("tpg_source: NUM_DESTS must not exceed N");
    end
    if (WIDTH > MAX_WIDTH) begin : g_err_width
        $error("tpg_source: WIDTH exceeds packing limit");
    end

    tpg_state_e        state_q, state_d;
    logic              valid_d, done_d;
    logic [WIDTH-1:0]  word_d;
    logic [DCW-1:0]    sent_d;
    logic [DCW-1:0]    data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
    logic [GAP_W-1:0]  gap_q, gap_d;

    function automatic logic [WIDTH-1:0] make_word(input logic [DCW-1:0] d,
                                                   input logic [IDX_W-1:0] i);
        logic [MAX_WIDTH-1:0] dst_v;
        logic [MAX_WIDTH-1:0] vc_v;
        dst_v = MAX_WIDTH'((DEST_BASE + int'(i)) % N);
        vc_v  = MAX_WIDTH'(d % DCW'(NUM_VC));
        return WIDTH'(pack(POS, N_ADDR_WIDTH, VC_ADDR_WIDTH, DCW,
                           MAX_WIDTH'(NODE), '0, MAX_WIDTH'(NODE),
                           dst_v, vc_v, MAX_WIDTH'(ID), MAX_WIDTH'(d)));
    endfunction

    assign idx_next = (idx_q == IDX_W'(NUM_DESTS - 1)) ? '0 : idx_q + 1'b1;

    // NOTE: every state register updates with <= so all flops see pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_out  <= 1'b0;
            data_out   <= '0;
            done       <= 1'b0;
            sent_count <= '0;
            data_q     <= DCW'(1);
            idx_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_out  <= valid_d;
            data_out   <= word_d;
            done       <= done_d;
            sent_count <= sent_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
        end
    end

    // NOTE: hold-by-default assignments up front keep this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        valid_d = valid_out;
        word_d  = data_out;
        done_d  = done;
        sent_d  = sent_count;
        data_d  = data_q;
        idx_d   = idx_q;
        gap_d   = gap_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    word_d  = make_word(data_q, idx_q);
                end
            end
            SEND: begin
                // The presented word is only replaced after a completed transfer.
                if (valid_out && ready_in) begin
                    sent_d = sent_count + 1'b1;
                    if (data_q == LAST_DATA) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d = data_q + 1'b1;
                        idx_d  = idx_next;
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            gap_d   = GAP_W'(GAP_CYCLES - 1);
                        end else if (enable) begin
                            valid_d = 1'b1;
                            word_d  = make_word(data_q + 1'b1, idx_next);
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (enable) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    word_d  = make_word(data_q, idx_q);
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tpg_source.sv
// Directed bench for tpg_source: three instances cover back-to-back, gapped and short streams.
module tb_tpg_source;

    localparam int DCW = 10;

    logic clk = 1'b0;
    logic rst;
    logic en_a, rdy_a, en_g, rdy_g, en_n, rdy_n;

    logic [31:0]    data_a, data_g, data_n;
    logic           valid_a, valid_g, valid_n;
    logic           done_a, done_g, done_n;
    logic [DCW-1:0] sent_a, sent_g, sent_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tpg_source #(.ID(8'd3), .DEST_BASE(5), .NUM_DESTS(4), .GAP_CYCLES(0), .NUM_TESTS(1000)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .data_out(data_a), .valid_out(valid_a),
        .ready_in(rdy_a), .done(done_a), .sent_count(sent_a));

    tpg_source #(.ID(8'd3), .DEST_BASE(5), .NUM_DESTS(4), .GAP_CYCLES(3), .NUM_TESTS(1000)) dut_g (
        .clk(clk), .rst(rst), .enable(en_g), .data_out(data_g), .valid_out(valid_g),
        .ready_in(rdy_g), .done(done_g), .sent_count(sent_g));

    tpg_source #(.ID(8'd3), .DEST_BASE(5), .NUM_DESTS(4), .GAP_CYCLES(0), .NUM_TESTS(4)) dut_n (
        .clk(clk), .rst(rst), .enable(en_n), .data_out(data_n), .valid_out(valid_n),
        .ready_in(rdy_n), .done(done_n), .sent_count(sent_n));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Hand-packed words: DST<<19 | VC<<18 | ID(3)<<10 | DATA, with NODE=0.
    logic [31:0] stream_words [6] = '{32'h002C0C01, 32'h00300C02, 32'h003C0C03,
                                      32'h00400C04, 32'h002C0C05, 32'h00300C06};
    logic        gap_valid    [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        en_a = 1'b0; rdy_a = 1'b0;
        en_g = 1'b0; rdy_g = 1'b0;
        en_n = 1'b0; rdy_n = 1'b0;
        tick();
        tick();
        check("reset_valid", valid_a, 0);
        check("reset_data", data_a, 0);
        check("reset_done", done_a, 0);
        check("reset_sent", sent_a, 0);

        // Back-to-back stream, DST wraps 5,6,7,8,5.
        rst = 1'b0; en_a = 1'b1; rdy_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stream_valid%0d", i), valid_a, 1);
            check($sformatf("stream_word%0d", i), data_a, stream_words[i]);
            check($sformatf("stream_sent%0d", i), sent_a, i);
        end

        // Backpressure: word 5 held for 7 cycles, counted once.
        rdy_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("bp_word%0d", i), data_a, 32'h002C0C05);
            check($sformatf("bp_valid%0d", i), valid_a, 1);
            check($sformatf("bp_sent%0d", i), sent_a, 4);
        end
        rdy_a = 1'b1;
        tick();
        check("bp_release_sent", sent_a, 5);
        check("bp_release_word", data_a, stream_words[5]);

        // enable drops while the word is stalled: it stays until accepted, then nothing more.
        rdy_a = 1'b0; en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("endrop_hold%0d", i), data_a, 32'h00300C06);
            check($sformatf("endrop_valid%0d", i), valid_a, 1);
        end
        rdy_a = 1'b1;
        tick();
        check("endrop_after_valid", valid_a, 0);
        check("endrop_after_sent", sent_a, 6);
        tick();
        tick();
        check("endrop_idle_valid", valid_a, 0);
        en_a = 1'b1;
        tick();
        check("endrop_resume_valid", valid_a, 1);
        check("endrop_resume_word", data_a, 32'h003C0C07);

        // Gapped stream: valid pattern 1,0,0,0,1,0,0,0,1.
        en_g = 1'b1; rdy_g = 1'b1;
        tick();
        check("gap_first_valid", valid_g, 1);
        check("gap_first_word", data_g, stream_words[0]);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("gap_valid%0d", i), valid_g, gap_valid[i]);
            if (i == 3) check("gap_word2", data_g, stream_words[1]);
            if (i == 7) check("gap_word3", data_g, stream_words[2]);
        end
        en_g = 1'b0;

        // Short stream: NUM_TESTS=4 gives exactly five packets, then done.
        en_n = 1'b1; rdy_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("short_word%0d", i), data_n, stream_words[i]);
            check($sformatf("short_done%0d", i), done_n, 0);
        end
        tick();
        check("short_end_valid", valid_n, 0);
        check("short_end_done", done_n, 1);
        check("short_end_sent", sent_n, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("short_stay_valid%0d", i), valid_n, 0);
            check($sformatf("short_stay_done%0d", i), done_n, 1);
        end

        // Mid-run reset: outputs clear, done clears, next run restarts at DATA=1, DST=5.
        rst = 1'b1;
        tick();
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_sent", sent_a, 0);
        check("rst_done_n", done_n, 0);
        check("rst_valid_n", valid_n, 0);
        rst = 1'b0;
        tick();
        check("restart_word", data_a, stream_words[0]);
        check("restart_sent", sent_a, 0);
        tick();
        check("restart_word2", data_a, stream_words[1]);
        check("restart_sent2", sent_a, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
